// File: rtl/i2f96_seq_pkg.sv
// fp96 format constants and the integer-to-float sequencer state type.
// Layout is {sign, exponent[EMSB:0], fraction[FMSB:0]}, 1+15+80 = 96 bits.
package fp96Pkg;
  localparam int MSB   = 95;
  localparam int EMSB  = 14;
  localparam int FMSB  = 79;
  localparam int FPWID = 96;

  localparam logic [EMSB:0] BIAS = (EMSB+1)'({EMSB{1'b1}});

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } i2f_state_t;
endpackage

// File: rtl/i2f96_seq_chunk_lzc.sv
// Combinational leading-zero count over one W-bit normalisation chunk.
// zero_o flags an all-zero chunk; cnt_o is then 0 and must be ignored.
module fp_chunk_lzc #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    cnt_o  = '0;
    zero_o = 1'b1;
    for (int k = 0; k < W; k++) begin
      if (d_i[k]) begin
        cnt_o  = CW'(W - 1 - k);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2f96_seq.sv
// Iterative 96-bit integer to fp96 converter: normalises SHSTEP bits per cycle, then rounds RNE.
// Result appears floor(lz/SHSTEP)+3 cycles after acceptance (1 for zero); held until out_ready.
module i2f96_seq
  import fp96Pkg::*;
#(
  parameter int SHSTEP = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [MSB:0] i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [MSB:0] o,
  output logic         inexact
);

  localparam int CW   = (SHSTEP > 1) ? $clog2(SHSTEP) : 1;
  localparam int GBIT = MSB - FMSB - 2;

  i2f_state_t   state_q, state_d;
  logic [MSB:0] mag_q, mag_d;
  logic [EMSB:0] exp_q, exp_d;
  logic         sgn_q, sgn_d;
  logic [MSB:0] o_q, o_d;
  logic         inexact_q, inexact_d;
  logic         out_valid_q, out_valid_d;

  logic          in_sgn;
  logic [MSB:0]  in_mag;
  logic [CW-1:0] lz_cnt;
  logic          chunk_zero;
  logic [FMSB:0] frac;
  logic          guard, sticky, round_up;
  logic [FMSB+1:0] frac_sum;

  assign in_sgn = op & i[MSB];
  assign in_mag = in_sgn ? -i : i;

  fp_chunk_lzc #(
    .W  (SHSTEP),
    .CW (CW)
  ) u_lzc (
    .d_i    (mag_q[MSB -: SHSTEP]),
    .cnt_o  (lz_cnt),
    .zero_o (chunk_zero)
  );

  // Hidden bit sits at MSB once normalised; it is dropped from the fraction.
  assign frac     = mag_q[MSB-1 -: FMSB+1];
  assign guard    = mag_q[GBIT];
  assign sticky   = |mag_q[GBIT-1:0];
  assign round_up = guard & (sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + {{(FMSB+1){1'b0}}, round_up};

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sgn_d       = sgn_q;
    o_d         = o_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sgn_d = in_sgn;
          mag_d = in_mag;
          exp_d = BIAS + (EMSB+1)'(MSB);
          if (in_mag == '0) begin
            o_d         = '0;
            inexact_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (chunk_zero) begin
          mag_d = mag_q << SHSTEP;
          exp_d = exp_q - (EMSB+1)'(SHSTEP);
        end else begin
          mag_d   = mag_q << lz_cnt;
          exp_d   = exp_q - (EMSB+1)'(lz_cnt);
          state_d = ROUND;
        end
      end
      ROUND: begin
        // A carry out of the fraction leaves frac_sum[FMSB:0] at zero already.
        o_d         = {sgn_q, exp_q + (EMSB+1)'(frac_sum[FMSB+1]), frac_sum[FMSB:0]};
        inexact_d   = guard | sticky;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sgn_q       <= 1'b0;
      o_q         <= '0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sgn_q       <= sgn_d;
      o_q         <= o_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign inexact   = inexact_q;

endmodule
